// File: rtl/tx_scrambler_128b130b.sv
// tx_scrambler_128b130b: per-lane 128b/130b TX scrambler feeding Sync_Logic.
// Data-block symbols are scrambled with the Gen3+ LFSR (X^23+X^21+X^16+X^8+X^5+X^2+1).
// Ordered-set symbols pass clear. SKP blocks freeze the LFSR. EIEOS reseeds it at the block end.
// Optional feature macro: TX_SCR_BYPASS_EN adds scr_bypass, which passes data blocks unscrambled.
module tx_scrambler_128b130b #(
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 4,
  parameter int unsigned LFSR_WIDTH   = 23,
  parameter logic [LFSR_WIDTH-1:0] LANE_SEED = LFSR_WIDTH'(23'h1DBFBC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
`ifdef TX_SCR_BYPASS_EN
  input  logic                    scr_bypass,
`endif
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  input  logic                    block_type,
  input  logic [CNT_WIDTH-1:0]    symbol_cnt,
  input  logic                    back_pressure,
  output logic [SYMBOL_WIDTH-1:0] scrambled_data,
  output logic                    sync_sel,
  output logic [LFSR_WIDTH-1:0]   lfsr_state
);

  localparam logic [LFSR_WIDTH-1:0]   LFSR_MASK = LFSR_WIDTH'(23'h210125);
  localparam logic [CNT_WIDTH-1:0]    CNT_FIRST = '0;
  localparam logic [CNT_WIDTH-1:0]    CNT_LAST  = '1;
  localparam logic [SYMBOL_WIDTH-1:0] SKP_SYM   = SYMBOL_WIDTH'(8'hAA);
  localparam logic [SYMBOL_WIDTH-1:0] EIEOS_SYM = SYMBOL_WIDTH'(8'h00);

  typedef enum logic [1:0] {
    OS_NONE  = 2'd0,
    OS_SKP   = 2'd1,
    OS_EIEOS = 2'd2,
    OS_OTHER = 2'd3
  } os_kind_t;

  logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic                    blk_os_q, blk_os_d;
  os_kind_t                os_kind_q, os_kind_d;
  logic                    reseed_pend_q, reseed_pend_d;

  logic                    advance;
  logic                    first_sym;
  logic                    last_sym;
  logic                    cur_os;
  os_kind_t                sym0_kind;
  os_kind_t                cur_kind;
  logic                    bypass;
  logic [LFSR_WIDTH-1:0]   lfsr_walk;
  logic [SYMBOL_WIDTH-1:0] scr_byte;

`ifdef TX_SCR_BYPASS_EN
  assign bypass = scr_bypass;
`else
  assign bypass = 1'b0;
`endif

  // State register: LFSR, block-type latch, ordered-set kind and pending reseed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q        <= LANE_SEED;
      blk_os_q      <= 1'b0;
      os_kind_q     <= OS_NONE;
      reseed_pend_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      blk_os_q      <= blk_os_d;
      os_kind_q     <= os_kind_d;
      reseed_pend_q <= reseed_pend_d;
    end
  end

  // Symbol classification and 8-step bit-serial LFSR walk for the current byte.
  always_comb begin
    advance   = enable & ~back_pressure;
    first_sym = (symbol_cnt == CNT_FIRST);
    last_sym  = (symbol_cnt == CNT_LAST);
    cur_os    = first_sym ? block_type : blk_os_q;

    if (in_data == SKP_SYM)        sym0_kind = OS_SKP;
    else if (in_data == EIEOS_SYM) sym0_kind = OS_EIEOS;
    else                           sym0_kind = OS_OTHER;

    if (first_sym) cur_kind = block_type ? sym0_kind : OS_NONE;
    else           cur_kind = os_kind_q;

    lfsr_walk = lfsr_q;
    scr_byte  = '0;
    for (int i = 0; i < int'(SYMBOL_WIDTH); i++) begin
      scr_byte[i] = in_data[i] ^ lfsr_walk[LFSR_WIDTH-1];
      lfsr_walk   = {lfsr_walk[LFSR_WIDTH-2:0], 1'b0} ^
                    (lfsr_walk[LFSR_WIDTH-1] ? LFSR_MASK : '0);
    end
  end

  // Next state: advance/freeze/reseed the LFSR and track block attributes on consumed symbols.
  always_comb begin
    lfsr_d        = lfsr_q;
    blk_os_d      = blk_os_q;
    os_kind_d     = os_kind_q;
    reseed_pend_d = reseed_pend_q;

    if (advance) begin
      if (last_sym && (reseed_pend_q || (cur_os && cur_kind == OS_EIEOS))) begin
        lfsr_d = LANE_SEED;
      end else if (!(cur_os && cur_kind == OS_SKP)) begin
        lfsr_d = lfsr_walk;
      end

      if (first_sym) begin
        blk_os_d      = block_type;
        os_kind_d     = cur_kind;
        reseed_pend_d = cur_os && (cur_kind == OS_EIEOS);
      end

      if (last_sym) begin
        os_kind_d     = OS_NONE;
        reseed_pend_d = 1'b0;
      end
    end
  end

  // Zero-latency outputs to Sync_Logic; forced to reset values while rst is asserted.
  always_comb begin
    scrambled_data = '0;
    sync_sel       = 1'b1;
    if (rst) begin
      sync_sel = ~cur_os;
      if (enable) begin
        scrambled_data = (cur_os || bypass) ? in_data : scr_byte;
      end
    end
  end

  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_tx_scrambler_128b130b.sv
// tb_tx_scrambler_128b130b: directed block-level bench with a bit-serial LFSR reference model.
module tb_tx_scrambler_128b130b;

  localparam logic [22:0] SEED = 23'h1DBFBC;
  localparam logic [22:0] MASK = 23'h210125;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        scr_bypass;
  logic [7:0]  in_data;
  logic        block_type;
  logic [3:0]  symbol_cnt;
  logic        back_pressure;
  logic [7:0]  scrambled_data;
  logic        sync_sel;
  logic [22:0] lfsr_state;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic [7:0]  exp_data;
  logic        exp_sync;
  logic [22:0] exp_lfsr;
  logic [22:0] m_lfsr;
  logic        byp = 1'b0;

  always #5 clk = ~clk;

  tx_scrambler_128b130b dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
`ifdef TX_SCR_BYPASS_EN
    .scr_bypass     (scr_bypass),
`endif
    .in_data        (in_data),
    .block_type     (block_type),
    .symbol_cnt     (symbol_cnt),
    .back_pressure  (back_pressure),
    .scrambled_data (scrambled_data),
    .sync_sel       (sync_sel),
    .lfsr_state     (lfsr_state)
  );

  assign scr_bypass = byp;

  // Reference LFSR: one shift of the Galois register, MSB is the output bit.
  function automatic logic [22:0] lfsr_adv(input logic [22:0] s, input int n);
    logic [22:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = {r[21:0], 1'b0} ^ (r[22] ? MASK : 23'h0);
    return r;
  endfunction

  function automatic logic [7:0] scramble(input logic [22:0] s, input logic [7:0] b);
    logic [7:0]  o;
    logic [22:0] r;
    r = s;
    for (int k = 0; k < 8; k++) begin
      o[k] = b[k] ^ r[22];
      r = lfsr_adv(r, 1);
    end
    return o;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every checked cycle, outputs must match the model expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("scrambled_data", 32'(scrambled_data), 32'(exp_data));
      check("sync_sel", 32'(sync_sel), 32'(exp_sync));
      check("lfsr_state", 32'(lfsr_state), 32'(exp_lfsr));
    end
  end

  // Drives the first n symbols of a block; optional one-cycle stall at stall_at.
  task automatic run_block(input logic bt, input logic [7:0] d[16], input int n,
                           input int stall_at, input logic reload);
    int kind;
    if (!bt)             kind = 0;
    else if (d[0] == 8'hAA) kind = 1;
    else if (d[0] == 8'h00) kind = 2;
    else                 kind = 3;
    for (int i = 0; i < n; i++) begin
      enable        = 1'b1;
      block_type    = bt;
      in_data       = d[i];
      symbol_cnt    = 4'(i);
      back_pressure = 1'b0;
      exp_data      = (bt || byp) ? d[i] : scramble(m_lfsr, d[i]);
      exp_sync      = ~bt;
      exp_lfsr      = m_lfsr;
      chk_en        = 1'b1;
      if (i == stall_at) begin
        back_pressure = 1'b1;
        if (reload) symbol_cnt = 4'd1;
        tick();
        back_pressure = 1'b0;
        symbol_cnt    = 4'(i);
      end
      tick();
      if (kind != 1) m_lfsr = lfsr_adv(m_lfsr, 8);
    end
    if (n == 16 && kind == 2) m_lfsr = SEED;
    chk_en        = 1'b0;
    back_pressure = 1'b1;
  endtask

  logic [7:0]  blk [16];
  logic [22:0] saved;

  initial begin
    rst = 1'b0; enable = 1'b1; in_data = 8'h5A; block_type = 1'b0;
    symbol_cnt = 4'd3; back_pressure = 1'b0;
    m_lfsr = SEED;

    // Model pins, hand-computed from the seed.
    check("pin_model_byte0", 32'(scramble(SEED, 8'h00)), 32'h6C);
    check("pin_model_lfsr8", 32'(lfsr_adv(SEED, 8)), 32'h498C2E);

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_lfsr", 32'(lfsr_state), 32'(SEED));
    check("rst_data", 32'(scrambled_data), 32'h0);
    check("rst_sync", 32'(sync_sel), 32'h1);
    tick();
    back_pressure = 1'b1;
    rst = 1'b1;

    // First symbol presented but stalled: DUT pinned to hand-computed values.
    symbol_cnt = 4'd0; in_data = 8'h00; block_type = 1'b0;
    @(negedge clk);
    check("pin_dut_lfsr0", 32'(lfsr_state), 32'h1DBFBC);
    check("pin_dut_byte0", 32'(scrambled_data), 32'h6C);
    tick();

    // 1: data block of zeros.
    for (int i = 0; i < 16; i++) blk[i] = 8'h00;
    run_block(1'b0, blk, 16, -1, 1'b0);

    // 2: OTHER ordered set; LFSR advances 128 steps.
    saved = m_lfsr;
    blk[0] = 8'h1E;
    for (int i = 1; i < 16; i++) blk[i] = 8'(i * 3 + 1);
    run_block(1'b1, blk, 16, -1, 1'b0);
    @(negedge clk);
    check("os_adv128", 32'(lfsr_state), 32'(lfsr_adv(saved, 128)));

    // 3: SKP block freezes the LFSR.
    saved = m_lfsr;
    for (int i = 0; i < 15; i++) blk[i] = 8'hAA;
    blk[15] = 8'hE1;
    run_block(1'b1, blk, 16, 7, 1'b0);
    @(negedge clk);
    check("skp_hold", 32'(lfsr_state), 32'(saved));

    // 5: data block with a stalled symbol_cnt.
    for (int i = 0; i < 16; i++) blk[i] = 8'(i * 17);
    run_block(1'b0, blk, 16, 5, 1'b0);

    // 4: EIEOS reseeds at the block end.
    for (int i = 0; i < 16; i++) blk[i] = (i % 2 == 0) ? 8'h00 : 8'hFF;
    run_block(1'b1, blk, 16, -1, 1'b0);
    @(negedge clk);
    check("eieos_reseed", 32'(lfsr_state), 32'h1DBFBC);

    // Data block from seed, with symbol_cnt reloaded to 1 during a stall.
    for (int i = 0; i < 16; i++) blk[i] = 8'(8'hC3 ^ 8'(i));
    run_block(1'b0, blk, 16, 8, 1'b1);

    // Lane disabled: output zero and state holds.
    enable = 1'b0; back_pressure = 1'b0; symbol_cnt = 4'd0;
    block_type = 1'b1; in_data = 8'h33;
    @(negedge clk);
    check("dis_data", 32'(scrambled_data), 32'h0);
    tick();
    @(negedge clk);
    check("dis_hold", 32'(lfsr_state), 32'(m_lfsr));
    tick();
    enable = 1'b1; back_pressure = 1'b1;

    // OTHER ordered set after a data block.
    blk[0] = 8'h2D;
    for (int i = 1; i < 16; i++) blk[i] = 8'(8'hF0 - 8'(i));
    run_block(1'b1, blk, 16, 3, 1'b1);

    // 6: reset asserted at symbol 7 of a data block.
    for (int i = 0; i < 16; i++) blk[i] = 8'(8'h5C + 8'(i));
    run_block(1'b0, blk, 7, -1, 1'b0);
    symbol_cnt = 4'd7; in_data = 8'h77; back_pressure = 1'b0; block_type = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_lfsr", 32'(lfsr_state), 32'h1DBFBC);
    check("mid_rst_sync", 32'(sync_sel), 32'h1);
    check("mid_rst_data", 32'(scrambled_data), 32'h0);
    tick();
    back_pressure = 1'b1; symbol_cnt = 4'd0;
    rst = 1'b1;
    m_lfsr = SEED;
    tick();
    run_block(1'b0, blk, 16, -1, 1'b0);

`ifdef TX_SCR_BYPASS_EN
    // Bypass: data passes clear while the LFSR keeps stepping.
    byp = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 8'(8'h91 + 8'(i * 5));
    run_block(1'b0, blk, 16, 4, 1'b0);
    byp = 1'b0;
    run_block(1'b0, blk, 16, -1, 1'b0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
